// File: rtl/riscv_lsu_if.sv
// ---------------------------------------------------------------------------
// riscv_lsu_if.sv
// Bus interfaces around the load/store unit.
//
// riscv_lsu_core_if : core <-> LSU
//   master = core, slave = LSU
//   core_req_i, core_we_i, core_size_i[2:0], core_addr_i[31:0], core_wd_i[31:0]
//     : driven by the core
//   core_rd_o[31:0], core_stall_o, core_err_o
//     : driven by the LSU
//
// riscv_lsu_mem_if : LSU <-> data memory
//   master = LSU, slave = memory
//   mem_req_o, mem_we_o, mem_be_o[3:0], mem_addr_o[31:0], mem_wd_o[31:0]
//     : driven by the LSU
//   mem_rd_i[31:0], mem_ready_i
//     : driven by the memory
// ---------------------------------------------------------------------------
interface riscv_lsu_core_if;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        core_err_o;

  modport master (
    output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    input  core_rd_o, core_stall_o, core_err_o
  );

  modport slave (
    input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    output core_rd_o, core_stall_o, core_err_o
  );
endinterface

interface riscv_lsu_mem_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  modport master (
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
    input  mem_rd_i, mem_ready_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
    output mem_rd_i, mem_ready_i
  );
endinterface

// File: rtl/riscv_lsu.sv
// ---------------------------------------------------------------------------
// riscv_lsu.sv
// Load/store controller between a single-cycle core and a multi-cycle data
// memory with a ready handshake. Each core access is captured into holding
// registers, presented to memory for as long as the memory needs (bounded by
// TIMEOUT_CYCLES), and the read word is sign/zero-extended back to the core.
// The core is stalled until the access finishes.
//
// Parameters:
//   TIMEOUT_CYCLES : cycles allowed in ACCESS before abort (1..65535)
//
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous reset, active-low
//   core   : riscv_lsu_core_if.slave (request in, stall/err/read data out)
//   mem    : riscv_lsu_mem_if.master (request/lanes out, read data/ready in)
//
// Configuration macro:
//   LSU_MISALIGN_TRAP_EN : when defined, misaligned H/HU/W accesses skip
//                          the memory and return an error in DONE.
// ---------------------------------------------------------------------------
module riscv_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  riscv_lsu_core_if.slave   core,
  riscv_lsu_mem_if.master   mem
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      r_state;
  logic [15:0] r_cnt;
  logic        r_mem_req;
  logic        r_we;
  logic [2:0]  r_size;
  logic [1:0]  r_off;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wd;
  logic [31:0] r_rd;
  logic        r_err;

  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wd;
  logic        w_misalign;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  assign w_off = core.core_addr_i[1:0];

  // Lane steering for the incoming request. size[1:0] selects the width;
  // encodings 3, 6 and 7 fall through to word.
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    w_be = 4'b1111;
    w_wd = core.core_wd_i;
    case (core.core_size_i[1:0])
      2'b00: begin
        w_be = 4'b0001 << w_off;
        w_wd = {4{core.core_wd_i[7:0]}};
      end
      2'b01: begin
        w_be = 4'b0011 << {w_off[1], 1'b0};
        w_wd = {2{core.core_wd_i[15:0]}};
      end
      default: begin
        w_be = 4'b1111;
        w_wd = core.core_wd_i;
      end
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    w_misalign = 1'b0;
    case (core.core_size_i[1:0])
      2'b00:   w_misalign = 1'b0;
      2'b01:   w_misalign = w_off[0];
      default: w_misalign = (w_off != 2'b00);
    endcase
  end
`else
  assign w_misalign = 1'b0;
`endif

  // Read extension uses the captured size/offset, not the live core inputs.
  // Stores return the raw memory word so core_rd_o stays deterministic.
  always_comb begin
    w_byte = mem.mem_rd_i[{r_off, 3'b000} +: 8];
    w_half = r_off[1] ? mem.mem_rd_i[31:16] : mem.mem_rd_i[15:0];
    w_ext  = mem.mem_rd_i;
    if (!r_we) begin
      case (r_size[1:0])
        2'b00:   w_ext = r_size[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
        2'b01:   w_ext = r_size[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
        default: w_ext = mem.mem_rd_i;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples the pre-edge values of the others.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_mem_req <= 1'b0;
      r_we      <= 1'b0;
      r_size    <= '0;
      r_off     <= '0;
      r_addr    <= '0;
      r_be      <= '0;
      r_wd      <= '0;
      r_rd      <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (core.core_req_i) begin
            r_we   <= core.core_we_i;
            r_size <= core.core_size_i;
            r_off  <= w_off;
            r_addr <= {core.core_addr_i[31:2], 2'b00};
            r_be   <= w_be;
            r_wd   <= w_wd;
            r_cnt  <= '0;
            if (w_misalign) begin
              r_err   <= 1'b1;
              r_rd    <= '0;
              r_state <= S_DONE;
            end else begin
              r_mem_req <= 1'b1;
              r_state   <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          // Ready wins over an expiring counter on the same cycle.
          if (mem.mem_ready_i) begin
            r_rd      <= w_ext;
            r_mem_req <= 1'b0;
            r_state   <= S_DONE;
          end else if (r_cnt == LP_CNT_LAST) begin
            r_rd      <= '0;
            r_err     <= 1'b1;
            r_mem_req <= 1'b0;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_DONE: begin
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_mem_req <= 1'b0;
          r_err     <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  // NOTE: stall is combinational on core_req_i, so it is gated with rst_ni to
  // stay low while reset is held even if the core keeps requesting.
  assign core.core_stall_o = rst_ni &
                             (((r_state == S_IDLE) & core.core_req_i) |
                              (r_state == S_ACCESS));
  assign core.core_rd_o    = r_rd;
  assign core.core_err_o   = r_err;

  assign mem.mem_req_o  = r_mem_req;
  assign mem.mem_we_o   = r_we;
  assign mem.mem_be_o   = r_be;
  assign mem.mem_addr_o = r_addr;
  assign mem.mem_wd_o   = r_wd;

endmodule

// File: tb/tb_riscv_lsu.sv
// ---------------------------------------------------------------------------
// tb_riscv_lsu.sv
// Directed self-checking bench for riscv_lsu (TIMEOUT_CYCLES = 4).
// Expected read data / error per access is queued when the request is
// driven and popped when the DONE cycle is observed. Inputs change and
// outputs are sampled around the falling clock edge.
// Honours LSU_MISALIGN_TRAP_EN for the misaligned-word step.
// ---------------------------------------------------------------------------
module tb_riscv_lsu;

  logic clk;
  logic rst_n;

  riscv_lsu_core_if core_bus ();
  riscv_lsu_mem_if  mem_bus ();

  riscv_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .core   (core_bus),
    .mem    (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete core access with a memory that answers after `waits` idle
  // ACCESS cycles (waits < 0: never answers).
  task automatic do_access(
    input string       name,
    input logic        we,
    input logic [2:0]  size,
    input logic [31:0] addr,
    input logic [31:0] wd,
    input logic [31:0] rd_word,
    input int          waits,
    input logic [31:0] exp_rd,
    input logic        exp_err,
    input logic [31:0] exp_addr,
    input logic [3:0]  exp_be,
    input logic [31:0] exp_wd,
    input int          exp_req,
    input int          exp_stall
  );
    int          req_n;
    int          stall_n;
    int          cyc;
    bit          done;
    exp_t        e;
    logic [31:0] rd_prev;
    req_n   = 0;
    stall_n = 0;
    cyc     = 0;
    done    = 1'b0;
    rd_prev = '0;

    @(negedge clk);
    core_bus.core_req_i  = 1'b1;
    core_bus.core_we_i   = we;
    core_bus.core_size_i = size;
    core_bus.core_addr_i = addr;
    core_bus.core_wd_i   = wd;
    mem_bus.mem_rd_i     = rd_word;
    mem_bus.mem_ready_i  = 1'b0;
    sb_q.push_back('{exp_rd, exp_err});
    #1;
    if (core_bus.core_stall_o) stall_n++;

    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      // Core-side changes after acceptance must be ignored.
      core_bus.core_req_i  = 1'b0;
      core_bus.core_we_i   = 1'($urandom_range(0, 1));
      core_bus.core_size_i = 3'($urandom_range(0, 7));
      core_bus.core_addr_i = $urandom;
      core_bus.core_wd_i   = $urandom;
      mem_bus.mem_ready_i  = 1'b0;
      #1;
      if (mem_bus.mem_req_o) begin
        req_n++;
        check({name, ".mem_addr"}, mem_bus.mem_addr_o, exp_addr);
        check({name, ".mem_be"},   32'(mem_bus.mem_be_o), 32'(exp_be));
        check({name, ".mem_we"},   32'(mem_bus.mem_we_o), 32'(we));
        check({name, ".mem_wd"},   mem_bus.mem_wd_o, exp_wd);
        if (waits >= 0 && req_n == waits + 1) mem_bus.mem_ready_i = 1'b1;
      end
      if (core_bus.core_stall_o) begin
        stall_n++;
      end else begin
        done = 1'b1;
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check({name, ".rd"},  core_bus.core_rd_o, e.rd);
          check({name, ".err"}, 32'(core_bus.core_err_o), 32'(e.err));
        end
        rd_prev = core_bus.core_rd_o;
        // A request during DONE must neither stall nor be accepted.
        core_bus.core_req_i = 1'b1;
        #1;
        check({name, ".stall_in_done"}, 32'(core_bus.core_stall_o), 32'd0);
      end
    end
    mem_bus.mem_ready_i = 1'b0;

    if (!done) begin
      check({name, ".done_reached"}, 32'(done), 32'd1);
      sb_q.delete();
    end
    check({name, ".req_cycles"},   32'(req_n),   32'(exp_req));
    check({name, ".stall_cycles"}, 32'(stall_n), 32'(exp_stall));

    // Cycle after DONE: back in IDLE, read data held, error pulse over.
    @(negedge clk);
    #1;
    check({name, ".rd_hold"},     core_bus.core_rd_o, rd_prev);
    check({name, ".err_after"},   32'(core_bus.core_err_o), 32'd0);
    check({name, ".req_after"},   32'(mem_bus.mem_req_o), 32'd0);
    check({name, ".stall_idle"},  32'(core_bus.core_stall_o), 32'd1);
    core_bus.core_req_i = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".mem_req"}, 32'(mem_bus.mem_req_o), 32'd0);
    check({name, ".stall"},   32'(core_bus.core_stall_o), 32'd0);
    check({name, ".rd"},      core_bus.core_rd_o, 32'd0);
    check({name, ".err"},     32'(core_bus.core_err_o), 32'd0);
    check({name, ".we"},      32'(mem_bus.mem_we_o), 32'd0);
    check({name, ".be"},      32'(mem_bus.mem_be_o), 32'd0);
    check({name, ".addr"},    mem_bus.mem_addr_o, 32'd0);
    check({name, ".wd"},      mem_bus.mem_wd_o, 32'd0);
  endtask

  initial begin
    rst_n                = 1'b0;
    core_bus.core_req_i  = 1'b1;   // stall must stay low under reset anyway
    core_bus.core_we_i   = 1'b0;
    core_bus.core_size_i = 3'd2;
    core_bus.core_addr_i = '0;
    core_bus.core_wd_i   = '0;
    mem_bus.mem_rd_i     = '0;
    mem_bus.mem_ready_i  = 1'b0;

    #12;
    check_all_zero("reset");
    core_bus.core_req_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    //        name       we    size  addr          wd            rd_word       waits exp_rd        err   exp_addr      be       exp_wd       req stall
    do_access("lw",      1'b0, 3'd2, 32'h0000_0104, 32'h0,       32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b0, 32'h0000_0104, 4'b1111, 32'h0,        1, 2);
    do_access("sb",      1'b1, 3'd0, 32'h0000_0203, 32'h0000_00A5, 32'h1122_3344, 3, 32'h1122_3344, 1'b0, 32'h0000_0200, 4'b1000, 32'hA5A5_A5A5, 4, 5);
    do_access("lb",      1'b0, 3'd0, 32'h0000_0402, 32'h0,       32'h80FF_7F80, 0, 32'hFFFF_FFFF, 1'b0, 32'h0000_0400, 4'b0100, 32'h0,        1, 2);
    do_access("lbu",     1'b0, 3'd4, 32'h0000_0402, 32'h0,       32'h80FF_7F80, 1, 32'h0000_00FF, 1'b0, 32'h0000_0400, 4'b0100, 32'h0,        2, 3);
    do_access("lh",      1'b0, 3'd1, 32'h0000_0402, 32'h0,       32'h80FF_7F80, 2, 32'hFFFF_80FF, 1'b0, 32'h0000_0400, 4'b1100, 32'h0,        3, 4);
    do_access("lhu",     1'b0, 3'd5, 32'h0000_0402, 32'h0,       32'h80FF_7F80, 0, 32'h0000_80FF, 1'b0, 32'h0000_0400, 4'b1100, 32'h0,        1, 2);
    do_access("sh",      1'b1, 3'd1, 32'h0000_0006, 32'h1234_BEEF, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 1'b0, 32'h0000_0004, 4'b1100, 32'hBEEF_BEEF, 2, 3);
    do_access("size7",   1'b0, 3'd7, 32'h0000_0008, 32'h0,       32'h1357_9BDF, 0, 32'h1357_9BDF, 1'b0, 32'h0000_0008, 4'b1111, 32'h0,        1, 2);
    do_access("timeout", 1'b0, 3'd2, 32'h0000_0300, 32'h0,       32'h5555_5555, -1, 32'h0,        1'b1, 32'h0000_0300, 4'b1111, 32'h0,        4, 5);
    do_access("lbu_post",1'b0, 3'd4, 32'h0000_0301, 32'h0,       32'h0000_AB00, 0, 32'h0000_00AB, 1'b0, 32'h0000_0300, 4'b0010, 32'h0,        1, 2);
`ifdef LSU_MISALIGN_TRAP_EN
    do_access("lw_mis",  1'b0, 3'd2, 32'h0000_0102, 32'h0,       32'h1234_5678, 0, 32'h0,        1'b1, 32'h0000_0100, 4'b1111, 32'h0,        0, 1);
`else
    do_access("lw_mis",  1'b0, 3'd2, 32'h0000_0102, 32'h0,       32'h1234_5678, 0, 32'h1234_5678, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,        1, 2);
`endif

    // Reset in the middle of ACCESS, asserted between clock edges.
    @(negedge clk);
    core_bus.core_req_i  = 1'b1;
    core_bus.core_we_i   = 1'b1;
    core_bus.core_size_i = 3'd2;
    core_bus.core_addr_i = 32'h0000_0500;
    core_bus.core_wd_i   = 32'h0BAD_F00D;
    mem_bus.mem_ready_i  = 1'b0;
    @(negedge clk);
    #1;
    check("rst_mid.in_access", 32'(mem_bus.mem_req_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    core_bus.core_req_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_all_zero("rst_post");

    do_access("lw_after_rst", 1'b0, 3'd2, 32'h0000_0010, 32'h0, 32'h0F0F_0F0F, 0, 32'h0F0F_0F0F, 1'b0, 32'h0000_0010, 4'b1111, 32'h0, 1, 2);

    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Load/store controller between the single-cycle core's memory interface and a multi-cycle data memory with a ready handshake.
- Registers each core access, sequences the memory request, generates byte enables and write-data lane steering, and sign- or zero-extends read data.
- Holds the core with a stall until the access completes or times out.
- Drives the core's stall_i; the core's mem_req/we/size/addr/wd outputs connect to the core_* inputs.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in ACCESS waiting for mem_ready_i before abort; range 1..65535.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active-low
- core_req_i  in  1  core requests a memory access
- core_we_i  in  1  1 = store, 0 = load
- core_size_i  in  3  0=B, 1=H, 2=W, 4=BU, 5=HU; 3/6/7 treated as W
- core_addr_i  in  32  byte address
- core_wd_i  in  32  store data, in low bits
- core_rd_o  out  32  extended load data
- core_stall_o  out  1  hold core PC/state
- core_err_o  out  1  access aborted (timeout or misaligned)
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  byte enables
- mem_addr_o  out  32  word address, bits [1:0] = 0
- mem_wd_o  out  32  lane-steered store data
- mem_rd_i  in  32  memory read word
- mem_ready_i  in  1  memory completes access this cycle

Behaviour:
Reset (rst_ni low, asynchronous):
- State = IDLE; timeout counter = 0.
- All registered outputs = 0; core_stall_o forced 0 while rst_ni is low.
- A reset mid-ACCESS drops mem_req_o immediately and abandons the access.

FSM:
- IDLE: on core_req_i = 1, capture addr, size, we and wd into holding registers, clear counter, go to ACCESS.
- ACCESS: hold mem_req_o = 1.
  - On mem_ready_i: capture mem_rd_i, go to DONE.
  - When the counter reaches TIMEOUT_CYCLES-1 without ready: set error flag, go to DONE.
  - Otherwise increment the counter.
- DONE: lasts exactly one cycle, then IDLE.

Stall and outputs:
- core_stall_o = (IDLE and core_req_i) or ACCESS. Combinational; low in DONE.
- The core therefore advances on the DONE edge.
- mem_req_o is high exactly in ACCESS.
- mem_we_o, mem_be_o, mem_addr_o and mem_wd_o are driven from the holding registers and are stable throughout ACCESS.
- core_req_i and core_* changes during ACCESS or DONE are ignored.
- DONE returns to IDLE; a new request is accepted in the following IDLE cycle, with no back-to-back acceptance in DONE.

Latency:
- Stall is min 2 cycles (ready in the first ACCESS cycle).
- Max stall is TIMEOUT_CYCLES+1 cycles.

Lanes (off = addr[1:0]):
- B/BU: be = 0001 << off; wd = {4{wd[7:0]}}.
- H/HU: be = 0011 << {addr[1],0}; wd = {2{wd[15:0]}}.
- W: be = 1111; wd unchanged.

Read extension, valid in DONE (otherwise core_rd_o holds its last value):
- B: sign-extend byte[off].
- BU: zero-extend byte[off].
- H: sign-extend half[addr[1]].
- HU: zero-extend half[addr[1]].
- W: whole word.
- For stores core_rd_o is don't-care but deterministic: the captured word.

Error:
- core_err_o is a 1-cycle pulse in DONE on timeout; core_rd_o = 0 in that case.
- A store timeout leaves memory state undefined at system level; the LSU only reports it.

Simultaneous events:
- mem_ready_i on the same cycle the counter expires counts as success, with no error.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined:
  - H/HU with addr[0] = 1, or W with addr[1:0] != 0, skips ACCESS and goes IDLE -> DONE.
  - mem_req_o never asserts for that access; core_err_o pulses in DONE; core_rd_o = 0.
  - Stall lasts 1 cycle.
- Undefined: no check. The offending low bits are ignored per the lane rules above, and the access proceeds normally.

Test Plan:
- Load word, ready in first ACCESS cycle:
  - Stimulus: addr 0x0000_0104, size W, mem_rd_i 0xDEAD_BEEF.
  - Response: mem_addr_o 0x104, be 1111, stall high for 2 cycles, core_rd_o 0xDEADBEEF in DONE, err 0.
- Store byte with 3 wait cycles:
  - Stimulus: addr 0x0000_0203, size B, wd 0x0000_00A5, ready after 3 cycles.
  - Response: be 1000, mem_wd_o 0xA5A5_A5A5, mem_we_o 1, mem_req_o high for 4 cycles, stall 5 cycles.
- Signed/unsigned extension:
  - Stimulus: mem_rd_i 0x80FF_7F80 at addr 0x...2.
  - Response: B -> 0xFFFF_FFFF; BU -> 0x0000_00FF; H -> 0xFFFF_80FF; HU -> 0x0000_80FF.
- Timeout with TIMEOUT_CYCLES = 4 and mem_ready_i held low:
  - Response: mem_req_o high exactly 4 cycles, core_err_o pulses, core_rd_o 0.
  - Next request accepted normally.
- Reset mid-ACCESS:
  - Stimulus: drive rst_ni low asynchronously between clock edges.
  - Response: mem_req_o and core_stall_o drop without a clock edge; after release the FSM is IDLE and all outputs are 0.
- With LSU_MISALIGN_TRAP_EN:
  - Stimulus: W load at addr 0x0000_0102.
  - Response: mem_req_o stays 0, stall 1 cycle, err pulse.
  - Same stimulus without the macro: access issued at 0x100 with be 1111.
